// File: rtl/change_fifo.sv
// change_fifo
//
// Byte-granular elastic FIFO used to re-frame a byte stream. Each cycle a
// producer may push 0..4 bytes and a consumer may pop 0..4 bytes, so the two
// sides can work in different chunk sizes. Byte order is MSB-first on both
// ports: bits [31:24] hold the oldest byte of a word.
//
// Ports
//   clk         rising-edge clock for all logic
//   rst_n       synchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   Din         write word, valid bytes MSB-aligned
//   Din_index   number of bytes to push (values above 4 behave as 4)
//   wr_en       write strobe
//   Dout_index  number of bytes requested (values above 4 behave as 4)
//   rd_en       read strobe
//   Dout        popped bytes, MSB-aligned, unused low bytes zero (registered)
//   index       number of valid bytes in Dout, 0 means nothing valid (registered)
//
// A write that would overflow the FIFO, taking into account the bytes popped in
// the same cycle, is dropped as a whole. A read never returns bytes written in
// the same cycle.

module change_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Din,
  input  logic [3:0]  Din_index,
  input  logic        wr_en,
  input  logic [3:0]  Dout_index,
  input  logic        rd_en,
  output logic [31:0] Dout,
  output logic [3:0]  index
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [2:0]    wr_req;
  logic [2:0]    rd_req;
  logic [2:0]    n_rd;
  logic [2:0]    n_wr;
  logic          wr_ok;
  logic [CW-1:0] count_after_rd;
  logic [31:0]   dout_next;

  // Clamp requested sizes to 4 and limit the read to what is already stored.
  // The write is judged against the occupancy left after this cycle's read;
  // DEPTH >= 8 keeps count + 4 inside the count width.
  always_comb begin
    wr_req = (Din_index  > 4'd4) ? 3'd4 : Din_index[2:0];
    rd_req = (Dout_index > 4'd4) ? 3'd4 : Dout_index[2:0];
    n_rd   = 3'd0;
    if (rd_en) begin
      n_rd = (CW'(rd_req) > count) ? count[2:0] : rd_req;
    end
    n_wr           = wr_en ? wr_req : 3'd0;
    count_after_rd = count - CW'(n_rd);
    wr_ok          = (n_wr != 3'd0) && ((count_after_rd + CW'(n_wr)) <= CW'(DEPTH));
  end

  // Gather the bytes being popped, oldest into the top byte lane. Pointer
  // arithmetic is done at pointer width so accesses across the end of the
  // array wrap naturally.
  always_comb begin
    dout_next = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < n_rd) begin
        dout_next[8*(3-k) +: 8] = mem[rd_ptr + PW'(k)];
      end
    end
  end

  // Pointer, occupancy and output registers. Strobes are ignored while reset
  // is asserted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      Dout   <= 32'd0;
      index  <= 4'd0;
    end else begin
      Dout   <= dout_next;
      index  <= {1'b0, n_rd};
      rd_ptr <= rd_ptr + PW'(n_rd);
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(n_wr);
        count  <= count_after_rd + CW'(n_wr);
      end else begin
        count  <= count_after_rd;
      end
    end
  end

  // Byte storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst_n && wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < n_wr) begin
          mem[wr_ptr + PW'(k)] <= Din[8*(3-k) +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_change_fifo.sv
// tb_change_fifo
//
// Self-checking bench for change_fifo. A byte queue models the FIFO contents;
// each driven cycle updates the queue and produces the Dout/index values the
// DUT should present after that clock edge.

module tb_change_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Din;
  logic [3:0]  Din_index;
  logic        wr_en;
  logic [3:0]  Dout_index;
  logic        rd_en;
  logic [31:0] Dout;
  logic [3:0]  index;

  logic [7:0]  model_q [$];
  logic [31:0] exp_dout;
  logic [3:0]  exp_index;
  int          checks;
  int          passes;

  change_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Din        (Din),
    .Din_index  (Din_index),
    .wr_en      (wr_en),
    .Dout_index (Dout_index),
    .rd_en      (rd_en),
    .Dout       (Dout),
    .index      (index)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the queue model, then wait until
  // just after the clock edge so outputs can be sampled.
  task automatic apply_stimulus(input logic wr, input logic [31:0] d, input logic [3:0] di,
                                input logic rd, input logic [3:0] ri);
    int n_rd;
    int n_wr;
    wr_en      = wr;
    Din        = d;
    Din_index  = di;
    rd_en      = rd;
    Dout_index = ri;
    n_rd = rd ? ((ri > 4) ? 4 : int'(ri)) : 0;
    if (n_rd > model_q.size()) n_rd = model_q.size();
    exp_dout = 32'd0;
    for (int k = 0; k < n_rd; k++) exp_dout[31-8*k -: 8] = model_q.pop_front();
    exp_index = 4'(n_rd);
    n_wr = wr ? ((di > 4) ? 4 : int'(di)) : 0;
    if (model_q.size() + n_wr <= DEPTH) begin
      for (int k = 0; k < n_wr; k++) model_q.push_back(d[31-8*k -: 8]);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Reset with both strobes active must leave outputs cleared and FIFO empty.
  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; Din = $urandom; Din_index = 4'd4; Dout_index = 4'd4;
      @(posedge clk);
      #1;
      checks++;
      if (Dout !== 32'd0 || index !== 4'd0)
        $display("[TB] FAIL reset_hold: Dout=%h index=%0d expected 00000000/0", Dout, index);
      else passes++;
    end
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    model_q.delete();
    apply_stimulus(1'b0, 32'd0, 4'd0, 1'b1, 4'd4);
    checks++;
    if (index !== 4'd0 || Dout !== 32'd0)
      $display("[TB] FAIL reset_empty_read: Dout=%h index=%0d expected 00000000/0", Dout, index);
    else passes++;
  endtask

  // Mixed-granularity write/read with a same-cycle write and read.
  task automatic test_basic();
    apply_stimulus(1'b1, 32'h12345678, 4'd4, 1'b0, 4'd0);
    repeat (10) apply_stimulus(1'b0, 32'd0, 4'd0, 1'b0, 4'd0);
    checks++;
    if (index !== 4'd0 || Dout !== 32'd0)
      $display("[TB] FAIL idle_outputs: Dout=%h index=%0d expected 00000000/0", Dout, index);
    else passes++;
    apply_stimulus(1'b1, 32'h11223344, 4'd2, 1'b1, 4'd3);
    checks++;
    if (Dout !== 32'h12345600 || index !== 4'd3)
      $display("[TB] FAIL basic_read3: Dout=%h index=%0d expected 12345600/3", Dout, index);
    else passes++;
    apply_stimulus(1'b0, 32'd0, 4'd0, 1'b1, 4'd4);
    checks++;
    if (Dout !== 32'h78112200 || index !== 4'd3)
      $display("[TB] FAIL basic_read4: Dout=%h index=%0d expected 78112200/3", Dout, index);
    else passes++;
  endtask

  // Reading an empty FIFO returns nothing, even with a same-cycle write.
  task automatic test_empty();
    apply_stimulus(1'b1, 32'hAABBCCDD, 4'd4, 1'b1, 4'd4);
    checks++;
    if (Dout !== 32'd0 || index !== 4'd0)
      $display("[TB] FAIL empty_read: Dout=%h index=%0d expected 00000000/0", Dout, index);
    else passes++;
    apply_stimulus(1'b0, 32'd0, 4'd0, 1'b1, 4'd4);
    checks++;
    if (Dout !== 32'hAABBCCDD || index !== 4'd4)
      $display("[TB] FAIL empty_then_read: Dout=%h index=%0d expected aabbccdd/4", Dout, index);
    else passes++;
  endtask

  // Fill to capacity, check a dropped overflow write and a write that only
  // fits thanks to a same-cycle read, then drain and account for every byte.
  task automatic test_full();
    logic [31:0] first_word;
    int          total;
    first_word = $urandom;
    apply_stimulus(1'b1, first_word, 4'd4, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, $urandom, 4'd4, 1'b0, 4'd0);
    apply_stimulus(1'b1, 32'h01020304, 4'd1, 1'b0, 4'd0);
    apply_stimulus(1'b1, 32'hA1B2C3D4, 4'd2, 1'b1, 4'd4);
    checks++;
    if (Dout !== first_word || index !== 4'd4)
      $display("[TB] FAIL full_rd_wr: Dout=%h index=%0d expected %h/4", Dout, index, first_word);
    else passes++;
    total = 0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 32'd0, 4'd0, 1'b1, 4'd4);
      total += int'(index);
      checks++;
      if (Dout !== exp_dout || index !== exp_index)
        $display("[TB] FAIL full_drain: Dout=%h index=%0d expected %h/%0d", Dout, index, exp_dout, exp_index);
      else passes++;
    end
    checks++;
    if (total !== 14)
      $display("[TB] FAIL full_count: drained=%0d expected 14", total);
    else passes++;
  endtask

  // Three-byte chunks repeatedly straddle the end of the array.
  task automatic test_wrap();
    logic [31:0] word;
    logic [7:0]  b;
    for (int i = 0; i < 20; i++) begin
      b    = 8'(3 * i);
      word = {b, b + 8'd1, b + 8'd2, 8'h00};
      apply_stimulus(1'b1, word, 4'd3, 1'b0, 4'd0);
      apply_stimulus(1'b0, 32'd0, 4'd0, 1'b1, 4'd3);
      checks++;
      if (Dout !== word || index !== 4'd3)
        $display("[TB] FAIL wrap_%0d: Dout=%h index=%0d expected %h/3", i, Dout, index, word);
      else passes++;
    end
  endtask

  // Oversized byte counts behave as 4.
  task automatic test_clamp();
    apply_stimulus(1'b1, 32'hDEADBEEF, 4'd9, 1'b0, 4'd0);
    apply_stimulus(1'b0, 32'd0, 4'd0, 1'b1, 4'd15);
    checks++;
    if (Dout !== 32'hDEADBEEF || index !== 4'd4)
      $display("[TB] FAIL clamp: Dout=%h index=%0d expected deadbeef/4", Dout, index);
    else passes++;
  endtask

  // Random traffic across every index value, compared against the queue model.
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'($urandom), $urandom, 4'($urandom_range(0, 15)),
                     1'($urandom), 4'($urandom_range(0, 15)));
      checks++;
      if (Dout !== exp_dout || index !== exp_index)
        $display("[TB] FAIL random_%0d: Dout=%h index=%0d expected %h/%0d", i, Dout, index, exp_dout, exp_index);
      else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    Din = 32'd0; Din_index = 4'd0; Dout_index = 4'd0;
    test_reset();
    test_basic();
    test_empty();
    test_full();
    test_wrap();
    test_clamp();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
